// File: rtl/my_serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B, LSB first, one full-subtractor cell
// and a registered borrow, sequenced with a start/busy/done handshake.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for start; D/Bo hold the last result
//   ST_RUN  | one operand bit per clock, LSB first; busy=1
//   ST_DONE | one-cycle done pulse; start here begins the next op at once
module my_serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             w;

  logic accept;
  logic last;
  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic w_nxt;

  // Operands are accepted from IDLE and also from DONE for back-to-back runs.
  assign accept = start && (state != ST_RUN);
  assign last   = (state == ST_RUN) && (cnt == CW'(WIDTH - 1));

  assign a_bit = a_sr[0];
  assign b_bit = b_sr[0];
  assign d_bit = a_bit ^ b_bit ^ w;
  assign w_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & w);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last)  state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      cnt    <= '0;
      w      <= 1'b0;
      D      <= '0;
      Bo     <= 1'b0;
    end else if (accept) begin
      a_sr   <= A;
      b_sr   <= B;
      res_sr <= '0;
      cnt    <= '0;
      w      <= 1'b0;
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      w      <= w_nxt;
      cnt    <= cnt + CW'(1);
      if (last) begin
        D  <= {d_bit, res_sr[WIDTH-1:1]};
        Bo <= w_nxt;
      end
    end
  end

endmodule

// File: tb/tb_my_serial_subtractor.sv
// Directed and exhaustive checks for my_serial_subtractor (WIDTH=4): handshake
// timing, boundary operands, restart/abort behaviour and a full A/B sweep.
module tb_my_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [3:0] D;
  logic       Bo;

  int n_tests = 0;
  int n_fail  = 0;

  my_serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .D     (D),
    .Bo    (Bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op from idle and check the full handshake plus result.
  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] exp_d, input logic exp_bo);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, " busy"}, busy, 1);
      check({tag, " no_done"}, done, 0);
      tick();
    end
    check({tag, " done"}, done, 1);
    check({tag, " busy_low"}, busy, 0);
    check({tag, " D"}, D, exp_d);
    check({tag, " Bo"}, Bo, exp_bo);
    tick();
    check({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    tick();
    // start during reset must not launch anything
    A = 4'd5; B = 4'd2; start = 1'b1;
    tick();
    tick();
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst D", D, 0);
    check("rst Bo", Bo, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    check("idle busy", busy, 0);
    check("idle done", done, 0);
    check("idle D", D, 0);

    run_op("9-3", 4'd9, 4'd3, 4'd6, 1'b0);
    run_op("3-9", 4'd3, 4'd9, 4'hA, 1'b1);
    check("hold D", D, 4'hA);
    check("hold Bo", Bo, 1);
    run_op("0-15", 4'd0, 4'd15, 4'd1, 1'b1);
    run_op("15-15", 4'd15, 4'd15, 4'd0, 1'b0);
    run_op("0-0", 4'd0, 4'd0, 4'd0, 1'b0);

    // mid-run restart is ignored; DONE-cycle start chains immediately
    run_op("pre", 4'd6, 4'd1, 4'd5, 1'b0);
    A = 4'd12; B = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    check("mid busy0", busy, 1);
    tick();
    A = 4'd1; B = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    check("mid busy2", busy, 1);
    check("mid hold D", D, 4'd5);
    tick();
    tick();
    check("mid done", done, 1);
    check("mid D", D, 4'd7);
    check("mid Bo", Bo, 0);
    A = 4'd2; B = 4'd7; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b busy", busy, 1);
    check("b2b done_low", done, 0);
    check("b2b hold D", D, 4'd7);
    tick();
    tick();
    tick();
    check("b2b not_yet", done, 0);
    tick();
    check("b2b done", done, 1);
    check("b2b D", D, 4'hB);
    check("b2b Bo", Bo, 1);
    tick();
    check("b2b done_pulse", done, 0);

    // reset two cycles into RUN aborts without a done pulse
    A = 4'd9; B = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort D", D, 0);
    check("abort Bo", Bo, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("abort no_done", done, 0);
      tick();
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        A = 4'(a); B = 4'(b); start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        if (done !== 1'b1 || D !== 4'((a - b) & 15) || Bo !== (a < b ? 1'b1 : 1'b0)) begin
          $display("a=%0d b=%0d", a, b);
        end
        check("sweep done", done, 1);
        check("sweep D", D, 32'((a - b) & 15));
        check("sweep Bo", Bo, (a < b) ? 32'd1 : 32'd0);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
